// File: rtl/serial_rx.sv
// serial_rx: 8N1 UART receiver. Mid-bit sampling driven by a bit-period
// counter, LSB-first shift register, one-cycle valid / frame_err pulses.
module serial_rx #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]    sync;
  logic [1:0]    sync_fill;
  logic          rx_s;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          armed;

  assign rx_s = sync[1];
  assign busy = (state != IDLE);

  // Two-flop synchronizer; sync_fill marks when rx_s reflects the real line
  // rather than the reset value of the flops.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sync      <= 2'b11;
      sync_fill <= 2'b00;
    end else begin
      sync      <= {sync[0], rx};
      sync_fill <= {sync_fill[0], 1'b1};
    end
  end

  // Receive FSM: start-bit validation, data shifting, stop-bit check.
  // armed gates new frames until the line has genuinely been seen idle
  // (after reset and after a framing error / break).
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shift     <= 8'h00;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      armed     <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      if (rx_s && sync_fill[1]) begin
        armed <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (armed && !rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!rx_s) begin
              bit_idx <= 3'd0;
              state   <= DATA;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            shift   <= {rx_s, shift[7:1]};
            cnt     <= '0;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
            if (rx_s) begin
              data  <= shift;
              valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              armed     <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: drives 8N1 frames into serial_rx (CLKS_PER_BIT = 16) and
// compares received events against an event-list model of the line.
module tb_serial_rx;

  localparam int C = 16;

  logic       sysclk;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  serial_rx #(.CLKS_PER_BIT(C)) dut (
    .sysclk    (sysclk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  typedef struct {
    bit         ferr;
    logic [7:0] d;
  } ev_t;

  typedef struct {
    logic [7:0] payload;
    bit         stop_ok;
    int         gap;
    bit         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  ev_t  got_q[$];
  ev_t  exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   viol  = 0;
  int   busy_hi = 0;
  int   last_valid_cyc = 0;
  int   start_cyc = 0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_rst_n = 1'b0;
  logic [7:0] exp_last;

  always @(posedge sysclk) cyc <= cyc + 1;

  // Event recorder and invariant watcher, sampled on the falling edge.
  always @(negedge sysclk) begin
    if (valid) begin
      got_q.push_back('{ferr: 1'b0, d: data});
      last_valid_cyc = cyc;
    end
    if (frame_err) got_q.push_back('{ferr: 1'b1, d: data});
    if (busy) busy_hi = busy_hi + 1;
    if (valid && frame_err) viol = viol + 1;
    if (rst_n && prev_rst_n && !valid && (data !== prev_data)) viol = viol + 1;
    prev_data  = data;
    prev_rst_n = rst_n;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end else begin
      $display("ok   %s = %0h", name, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  // Start bit, eight data bits LSB-first, stop bit; a bad stop bit can be
  // extended into a break of low_hold extra cycles before the line idles.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int low_hold);
    start_cyc = cyc;
    rx = 1'b0;
    tick(C);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(C);
    end
    rx = stop_ok;
    tick(C);
    if (!stop_ok && low_hold > 0) tick(low_hold);
    rx = 1'b1;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{payload: 8'h00, stop_ok: 1'b1, gap: 3, exp_ferr: 1'b0, exp_data: 8'h00};
    vecs[1] = '{payload: 8'hFF, stop_ok: 1'b1, gap: 0, exp_ferr: 1'b0, exp_data: 8'hFF};
    vecs[2] = '{payload: 8'h5A, stop_ok: 1'b0, gap: 4, exp_ferr: 1'b1, exp_data: 8'hFF};
    vecs[3] = '{payload: 8'h81, stop_ok: 1'b1, gap: 2, exp_ferr: 1'b0, exp_data: 8'h81};
    vecs[4] = '{payload: 8'h7E, stop_ok: 1'b1, gap: 5, exp_ferr: 1'b0, exp_data: 8'h7E};
    vecs[5] = '{payload: 8'hC3, stop_ok: 1'b0, gap: 4, exp_ferr: 1'b1, exp_data: 8'h7E};

    rst_n = 1'b0;
    rx    = 1'b1;
    tick(3);
    chk("reset_data", 32'(data), 32'h00);
    chk("reset_valid", 32'(valid), 32'h0);
    chk("reset_ferr", 32'(frame_err), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    tick(6);
    chk("post_reset_busy", 32'(busy), 32'h0);

    // Single frame '5': value, latency, busy span.
    got_q.delete();
    busy_hi = 0;
    send_frame(8'h35, 1'b1, 0);
    tick(4);
    chk("f35_pulses", 32'(got_q.size()), 32'd1);
    if (got_q.size() >= 1) begin
      chk("f35_data", 32'(got_q[0].d), 32'h35);
      chk("f35_is_valid", 32'(got_q[0].ferr), 32'h0);
    end
    // 2 synchronizer cycles + (C-1)/2 + 9C + 1, allowed +-1
    chk("f35_latency_ok", 32'((last_valid_cyc - start_cyc >= 2 + (C-1)/2 + 9*C) &&
                              (last_valid_cyc - start_cyc <= 2 + (C-1)/2 + 9*C + 2)), 32'h1);
    chk("f35_busy_span_ok", 32'((busy_hi >= 150) && (busy_hi <= 154)), 32'h1);
    exp_last = 8'h35;

    // Back-to-back 'u','0' with one stop bit.
    got_q.delete();
    send_frame(8'h75, 1'b1, 0);
    send_frame(8'h30, 1'b1, 0);
    tick(4);
    chk("b2b_pulses", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      chk("b2b_first", 32'(got_q[0].d), 32'h75);
      chk("b2b_second", 32'(got_q[1].d), 32'h30);
    end
    exp_last = 8'h30;

    // 4-cycle low glitch on idle line.
    got_q.delete();
    busy_hi = 0;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(8);
    chk("glitch_busy_low", 32'(busy), 32'h0);
    chk("glitch_seen", 32'(busy_hi > 0), 32'h1);
    tick(C);
    chk("glitch_no_pulse", 32'(got_q.size()), 32'd0);

    // Bad stop bit followed by a 40-cycle break.
    got_q.delete();
    send_frame(8'hA5, 1'b0, 0);
    busy_hi = 0;
    rx = 1'b0;
    tick(40);
    chk("break_no_start", 32'(busy_hi), 32'd0);
    rx = 1'b1;
    tick(4);
    chk("ferr_pulses", 32'(got_q.size()), 32'd1);
    if (got_q.size() >= 1) begin
      chk("ferr_flag", 32'(got_q[0].ferr), 32'h1);
      chk("ferr_data_kept", 32'(got_q[0].d), 32'(exp_last));
    end
    chk("ferr_data_now", 32'(data), 32'(exp_last));

    // Vector table.
    for (int v = 0; v < 6; v++) begin
      got_q.delete();
      send_frame(vecs[v].payload, vecs[v].stop_ok, 0);
      tick(vecs[v].gap + 2);
      chk($sformatf("vec%0d_pulses", v), 32'(got_q.size()), 32'd1);
      if (got_q.size() == 1) begin
        chk($sformatf("vec%0d_ferr", v), 32'(got_q[0].ferr), 32'(vecs[v].exp_ferr));
        chk($sformatf("vec%0d_data", v), 32'(got_q[0].d), 32'(vecs[v].exp_data));
      end
    end
    exp_last = 8'h7E;

    // Reset during data bit 4, then a clean frame '9'.
    got_q.delete();
    rx = 1'b0;
    tick(C);
    for (int i = 0; i < 4; i++) begin
      rx = 1'(i & 1);
      tick(C);
    end
    rx = 1'b1;
    tick(C / 2);
    rst_n = 1'b0;
    #1;
    chk("midrst_data", 32'(data), 32'h00);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_valid", 32'(valid), 32'h0);
    chk("midrst_ferr", 32'(frame_err), 32'h0);
    tick(3);
    rst_n = 1'b1;
    tick(6);
    chk("midrst_no_pulse", 32'(got_q.size()), 32'd0);
    send_frame(8'h39, 1'b1, 0);
    tick(4);
    chk("after_rst_pulses", 32'(got_q.size()), 32'd1);
    if (got_q.size() == 1) chk("after_rst_data", 32'(got_q[0].d), 32'h39);
    exp_last = 8'h39;

    // Randomized frames against the event-list model.
    got_q.delete();
    exp_q.delete();
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      bit ok;
      int gap;
      b   = 8'($urandom_range(0, 255));
      ok  = ($urandom_range(0, 4) != 0);
      gap = ok ? int'($urandom_range(0, 4)) : int'($urandom_range(3, 6));
      if (ok) begin
        exp_last = b;
        exp_q.push_back('{ferr: 1'b0, d: b});
      end else begin
        exp_q.push_back('{ferr: 1'b1, d: exp_last});
      end
      send_frame(b, ok, 0);
      if (gap > 0) tick(gap);
    end
    tick(2 * C);
    chk("rand_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("rand%0d_ferr", i), 32'(got_q[i].ferr), 32'(exp_q[i].ferr));
      chk($sformatf("rand%0d_data", i), 32'(got_q[i].d), 32'(exp_q[i].d));
    end

    chk("invariant_violations", 32'(viol), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_rx.md
SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10417, giving sysclk cycles per serial bit period; legal range is 4 or more.
REQ-002 SHALL have port sysclk, input, 1 bit: the single clock, rising-edge active.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port rx, input, 1 bit: asynchronous serial line, 8N1 frames, idle high.
REQ-005 SHALL have port data, output, 8 bits: last correctly received byte.
REQ-006 SHALL have port valid, output, 1 bit: one-cycle pulse when data updates.
REQ-007 SHALL have port frame_err, output, 1 bit: one-cycle pulse when a stop bit samples low.
REQ-008 SHALL have port busy, output, 1 bit: high while a frame is in progress (any state other than IDLE).

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer that resets to 1; all logic uses only the synchronized value rx_s.
REQ-010 SHALL implement states IDLE, START, DATA, STOP, with a bit-period counter of width clog2(CLKS_PER_BIT) and a 3-bit bit index.
REQ-011 IDLE: when rx_s = 0, SHALL go to START and clear the counter.
REQ-012 START: at counter = (CLKS_PER_BIT-1)/2 (integer division), SHALL resample rx_s.
- If rx_s = 0, SHALL clear the counter and bit index and go to DATA.
- If rx_s = 1 (glitch), SHALL return to IDLE with no output pulse.
REQ-013 DATA: at counter = CLKS_PER_BIT-1, SHALL shift rx_s into the shift register LSB-first, clear the counter and increment the bit index.
- After the sample taken at bit index 7, SHALL go to STOP.
REQ-014 STOP: at counter = CLKS_PER_BIT-1, SHALL sample rx_s.
- If 1, SHALL load data from the shift register and pulse valid for exactly one cycle.
- If 0, SHALL pulse frame_err for exactly one cycle and leave data unchanged.
- Either way, SHALL return to IDLE on the same edge.
REQ-015 After a frame_err, SHALL stay in IDLE while rx_s = 0 (break condition) and SHALL start a new frame only after rx_s has been seen high for at least one cycle.
REQ-016 SHALL never assert valid and frame_err in the same cycle.
REQ-017 SHALL hold data stable between valid pulses; data SHALL only change on the cycle valid is high.
REQ-018 A falling edge on rx_s in the cycle the block returns to IDLE SHALL be detected on the next cycle; back-to-back frames with a one-bit stop SHALL all be received.
REQ-019 Total latency from the synchronized start-bit falling edge to the valid pulse SHALL be (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT + 1 cycles, within ±1 cycle.
REQ-020 The counter SHALL never exceed CLKS_PER_BIT-1 and the bit index SHALL wrap from 7 to 0 only on entry to STOP.
REQ-021 SHALL accept any byte value, including 8'h00, as valid data; payload interpretation belongs to the consumer.

Reset
REQ-022 On rst_n low, SHALL asynchronously force:
- state = IDLE;
- data = 8'h00, valid = 0, frame_err = 0, busy = 0;
- counter, bit index and shift register = 0;
- synchronizer flops = 1.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no valid or frame_err pulse.
- After release, SHALL ignore rx until rx_s has been seen high at least once.
REQ-024 Release of rst_n SHALL take effect synchronously to sysclk; first state change no earlier than the second rising edge after release.

Verification
REQ-025 Bench with CLKS_PER_BIT = 16: send frame 8'h35 ('5') -> one valid pulse, data = 8'h35, frame_err never high, busy high for about 9.5 bit periods.
REQ-026 Bench with CLKS_PER_BIT = 16: send 8'h75 ('u') immediately followed by 8'h30 ('0'), with one stop bit between -> two valid pulses, data 8'h75 then 8'h30.
REQ-027 Bench with CLKS_PER_BIT = 16: drive a 4-cycle low glitch on idle rx -> no valid pulse, busy returns low by cycle 10, state back to IDLE.
REQ-028 Bench with CLKS_PER_BIT = 16: send 8'hA5 with stop bit forced low, then hold rx low for 40 cycles, then high -> one frame_err pulse, data keeps its prior value, no new frame starts until rx goes high.
REQ-029 Bench with CLKS_PER_BIT = 16: assert rst_n low during data bit 4 of a frame, then release with rx high -> all outputs 0 and no pulses; a following frame of 8'h39 is received correctly.
